// File: rtl/port_receive_frame_buffer_pkg.sv
// Shared types and constants for the per-port receive frame buffer.
package receive_frame_buffer_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_RECEIVE,
    W_DROP
  } write_state_t;

  localparam int LAST_BIT   = 9;
  localparam int FIRST_BIT  = 8;
  localparam int WORD_WIDTH = 10;
  localparam int LEN_WIDTH  = 11;

  localparam int DEFAULT_MINIMUM_FRAME_LENGTH = 14;
  localparam int DEFAULT_MAXIMUM_FRAME_LENGTH = 1518;
  localparam int DEFAULT_DEPTH_LOG2           = 11;

endpackage

// File: rtl/port_receive_frame_buffer_if.sv
// Byte-side receive inputs and word-side valid/ready outputs of the frame buffer.
interface port_receive_frame_buffer_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_frame_start;
  logic       rx_frame_end;
  logic       rx_frame_error;
  logic       receive_data_ready;
  logic [8:0] receive_data;
  logic       receive_data_enable;

  modport master (
    output rx_data, rx_data_valid, rx_frame_start, rx_frame_end, rx_frame_error,
    output receive_data_ready,
    input  receive_data, receive_data_enable
  );

  modport slave (
    input  rx_data, rx_data_valid, rx_frame_start, rx_frame_end, rx_frame_error,
    input  receive_data_ready,
    output receive_data, receive_data_enable
  );
endinterface

// File: rtl/port_receive_frame_buffer_memory.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module frame_buffer_memory #(
  parameter int DEPTH_LOG2 = 11,
  parameter int WIDTH      = 10
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [DEPTH_LOG2-1:0] write_address,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [DEPTH_LOG2-1:0] read_address,
  output logic [WIDTH-1:0]      read_data
);
  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clock) begin
    if (write_enable) mem[write_address] <= write_data;
  end

  assign read_data = mem[read_address];
endmodule

// File: rtl/port_receive_frame_buffer.sv
// Store-and-forward receive buffer: only complete, good frames become visible.
// PORT_RECEIVE_FRAME_BUFFER_STATISTICS_EN keeps a saturating dropped-frame counter.
//   state     | meaning
//   W_IDLE    | waiting for a start-flagged byte
//   W_RECEIVE | writing an open frame speculatively past commit_wp
//   W_DROP    | discarding the remainder of a rejected frame
module port_receive_frame_buffer
  import receive_frame_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2           = DEFAULT_DEPTH_LOG2,
  parameter int MINIMUM_FRAME_LENGTH = DEFAULT_MINIMUM_FRAME_LENGTH,
  parameter int MAXIMUM_FRAME_LENGTH = DEFAULT_MAXIMUM_FRAME_LENGTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  port_receive_frame_buffer_if.slave bus,
  output logic                       frame_committed,
  output logic                       frame_dropped,
  output logic [15:0]                dropped_frame_count
);
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0]     DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LEN_WIDTH-1:0] MIN_LEN     = LEN_WIDTH'(MINIMUM_FRAME_LENGTH);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN     = LEN_WIDTH'(MAXIMUM_FRAME_LENGTH);

  write_state_t            state;
  logic [PTR_W-1:0]        spec_wp, commit_wp, rp, base_wp;
  logic [LEN_WIDTH-1:0]    len, base_len, len_next;
  logic                    gap, enable, pop;
  logic                    restart, accept, overflow, wr_en, good_end, bad_end, drop;
  logic [WORD_WIDTH-1:0]   wr_word, rd_word;

  frame_buffer_memory #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WORD_WIDTH)
  ) u_memory (
    .clock         (clock),
    .write_enable  (wr_en),
    .write_address (base_wp[DEPTH_LOG2-1:0]),
    .write_data    (wr_word),
    .read_address  (rp[DEPTH_LOG2-1:0]),
    .read_data     (rd_word)
  );

  // A start flag always restarts from the committed boundary, abandoning any open frame.
  always_comb begin
    restart  = bus.rx_data_valid & bus.rx_frame_start;
    base_wp  = restart ? commit_wp : spec_wp;
    base_len = restart ? '0 : len;
    accept   = bus.rx_data_valid & (restart | (state == W_RECEIVE));
    overflow = ((base_wp - rp) == DEPTH_WORDS) | (base_len >= MAX_LEN);
    wr_en    = accept & ~overflow;
    len_next = (base_len == '1) ? base_len : base_len + 1'b1;
    good_end = wr_en & bus.rx_frame_end & ~bus.rx_frame_error & (len_next >= MIN_LEN);
    bad_end  = wr_en & bus.rx_frame_end & ~good_end;
    drop     = (restart & (state == W_RECEIVE)) | (accept & overflow) | bad_end;
    wr_word  = {bus.rx_frame_end, restart, bus.rx_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= W_IDLE;
      spec_wp         <= '0;
      commit_wp       <= '0;
      len             <= '0;
      frame_committed <= 1'b0;
      frame_dropped   <= 1'b0;
    end else begin
      frame_committed <= good_end;
      frame_dropped   <= drop;
      if (good_end) begin
        spec_wp   <= base_wp + 1'b1;
        commit_wp <= base_wp + 1'b1;
        state     <= W_IDLE;
      end else if (wr_en && !bus.rx_frame_end) begin
        spec_wp <= base_wp + 1'b1;
        len     <= len_next;
        state   <= W_RECEIVE;
      end else if (drop) begin
        spec_wp <= commit_wp;
        state   <= bus.rx_frame_end ? W_IDLE : W_DROP;
      end else if (state == W_DROP && bus.rx_data_valid && bus.rx_frame_end) begin
        state <= W_IDLE;
      end
    end
  end

  // gap holds enable low for one cycle after a last word so the consumer sees frame boundaries.
  assign enable                  = (rp != commit_wp) & ~gap;
  assign pop                     = enable & bus.receive_data_ready;
  assign bus.receive_data_enable = enable;
  assign bus.receive_data        = enable ? rd_word[FIRST_BIT:0] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rp  <= '0;
      gap <= 1'b0;
    end else begin
      gap <= pop & rd_word[LAST_BIT];
      if (pop) rp <= rp + 1'b1;
    end
  end

`ifdef PORT_RECEIVE_FRAME_BUFFER_STATISTICS_EN
  logic [15:0] drop_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign dropped_frame_count = drop_count;
`else
  assign dropped_frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_port_receive_frame_buffer.sv
// Bench: a deep and a 16-word buffer share one stimulus; a queue-level model checks both every cycle.
module tb_port_receive_frame_buffer;
`ifdef PORT_RECEIVE_FRAME_BUFFER_STATISTICS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif
  localparam int MINLEN = 14;
  localparam int MAXLEN = 1518;

  logic clock = 1'b0;
  logic reset_n;
  logic [7:0] rx_data;
  logic rx_valid, rx_start, rx_end, rx_error, ready;

  logic committed_a, dropped_a, committed_b, dropped_b;
  logic [15:0] count_a, count_b;

  int errors = 0;
  int checks = 0;

  port_receive_frame_buffer_if bus_a ();
  port_receive_frame_buffer_if bus_b ();

  assign bus_a.rx_data = rx_data;         assign bus_b.rx_data = rx_data;
  assign bus_a.rx_data_valid = rx_valid;  assign bus_b.rx_data_valid = rx_valid;
  assign bus_a.rx_frame_start = rx_start; assign bus_b.rx_frame_start = rx_start;
  assign bus_a.rx_frame_end = rx_end;     assign bus_b.rx_frame_end = rx_end;
  assign bus_a.rx_frame_error = rx_error; assign bus_b.rx_frame_error = rx_error;
  assign bus_a.receive_data_ready = ready; assign bus_b.receive_data_ready = ready;

  port_receive_frame_buffer dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a),
    .frame_committed(committed_a), .frame_dropped(dropped_a), .dropped_frame_count(count_a)
  );

  port_receive_frame_buffer #(.DEPTH_LOG2(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b),
    .frame_committed(committed_b), .frame_dropped(dropped_b), .dropped_frame_count(count_b)
  );

  always #5 clock = ~clock;

  // model: per instance, committed words queue, pending open-frame queue, frame status
  logic [9:0]  cq [2][$];
  logic [9:0]  pq [2][$];
  int          mst [2];
  bit          mgap [2];
  bit          mc [2];
  bit          md [2];
  logic [15:0] mcnt [2];

  logic [8:0] rx_a [$];
  logic [8:0] rx_b [$];
  int n_commit_a = 0, n_drop_a = 0, n_drop_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cq[k].delete(); pq[k].delete();
      mst[k] = 0; mgap[k] = 1'b0; mc[k] = 1'b0; md[k] = 1'b0; mcnt[k] = 16'h0;
    end
  endtask

  task automatic model_step(input int k);
    int cap;
    bit pop, drop, done;
    logic [9:0] w;
    cap  = (k == 0) ? 2048 : 16;
    pop  = (cq[k].size() > 0) && !mgap[k] && ready;
    drop = 1'b0; done = 1'b0; mc[k] = 1'b0;
    if (rx_valid) begin
      if (rx_start) begin
        if (mst[k] == 1) begin drop = 1'b1; pq[k].delete(); end
        if (cq[k].size() >= cap) begin
          drop = 1'b1; mst[k] = rx_end ? 0 : 2;
        end else begin
          pq[k].push_back({rx_end, 1'b1, rx_data}); mst[k] = 1; done = rx_end;
        end
      end else if (mst[k] == 1) begin
        if (cq[k].size() + pq[k].size() >= cap || pq[k].size() >= MAXLEN) begin
          drop = 1'b1; pq[k].delete(); mst[k] = rx_end ? 0 : 2;
        end else begin
          pq[k].push_back({rx_end, 1'b0, rx_data}); done = rx_end;
        end
      end else if (mst[k] == 2 && rx_end) begin
        mst[k] = 0;
      end
      if (done) begin
        if (rx_error || pq[k].size() < MINLEN) begin
          drop = 1'b1; pq[k].delete();
        end else begin
          while (pq[k].size() > 0) cq[k].push_back(pq[k].pop_front());
          mc[k] = 1'b1;
        end
        mst[k] = 0;
      end
    end
    if (pop) begin w = cq[k].pop_front(); mgap[k] = w[9]; end
    else mgap[k] = 1'b0;
    md[k] = drop;
    if (drop && mcnt[k] != 16'hFFFF) mcnt[k] = mcnt[k] + 16'd1;
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic compare_one(input int k, input logic en, input logic [8:0] data,
                             input logic c, input logic d, input logic [15:0] cnt);
    logic en_exp;
    logic [9:0] head;
    logic [8:0] data_exp;
    string p;
    p = (k == 0) ? "a" : "b";
    en_exp = (cq[k].size() > 0) && !mgap[k];
    head = en_exp ? cq[k][0] : 10'h0;
    data_exp = head[8:0];
    check({p, "_enable"}, 32'(en), 32'(en_exp));
    check({p, "_data"}, 32'(data), 32'(data_exp));
    check({p, "_committed"}, 32'(c), 32'(mc[k]));
    check({p, "_dropped"}, 32'(d), 32'(md[k]));
    check({p, "_count"}, 32'(cnt), STAT ? 32'(mcnt[k]) : 32'h0);
  endtask

  initial forever begin
    @(negedge clock);
    compare_one(0, bus_a.receive_data_enable, bus_a.receive_data, committed_a, dropped_a, count_a);
    compare_one(1, bus_b.receive_data_enable, bus_b.receive_data, committed_b, dropped_b, count_b);
    if (bus_a.receive_data_enable && ready) rx_a.push_back(bus_a.receive_data);
    if (bus_b.receive_data_enable && ready) rx_b.push_back(bus_b.receive_data);
    if (committed_a) n_commit_a++;
    if (dropped_a) n_drop_a++;
    if (dropped_b) n_drop_b++;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit s, input bit e, input bit er);
    rx_data = d; rx_valid = 1'b1; rx_start = s; rx_end = e; rx_error = er;
    @(posedge clock); #2;
    rx_valid = 1'b0; rx_start = 1'b0; rx_end = 1'b0; rx_error = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input bit er, input bit close);
    for (int i = 0; i < n; i++)
      send_byte(base + 8'(i), i == 0, close && i == n - 1, er && close && i == n - 1);
  endtask

  function automatic logic [31:0] word_at(input int which, input int idx);
    if (which == 0) return (rx_a.size() > idx) ? 32'(rx_a[idx]) : 32'hDEAD;
    return (rx_b.size() > idx) ? 32'(rx_b[idx]) : 32'hDEAD;
  endfunction

  initial begin
    rx_data = 8'h0; rx_valid = 1'b0; rx_start = 1'b0; rx_end = 1'b0; rx_error = 1'b0;
    ready = 1'b1; reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("reset_a_enable", 32'(bus_a.receive_data_enable), 32'h0);
    check("reset_a_data", 32'(bus_a.receive_data), 32'h0);
    check("reset_a_count", 32'(count_a), 32'h0);
    check("reset_b_enable", 32'(bus_b.receive_data_enable), 32'h0);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    idle(2);

    // good 60-byte frame
    send_frame(60, 8'h00, 1'b0, 1'b1);
    idle(70);
    check("t1_a_words", 32'(rx_a.size()), 32'd60);
    check("t1_a_first", word_at(0, 0), 32'h100);
    check("t1_a_second", word_at(0, 1), 32'h001);
    check("t1_a_last", word_at(0, 59), 32'h03B);
    check("t1_a_commits", 32'(n_commit_a), 32'd1);

    // errored frame then a good one
    send_frame(60, 8'h00, 1'b1, 1'b1);
    idle(5);
    check("t2_a_drops", 32'(n_drop_a), 32'd1);
    check("t2_a_count", 32'(count_a), STAT ? 32'd1 : 32'd0);
    check("t2_a_words_after_err", 32'(rx_a.size()), 32'd60);
    send_frame(60, 8'h00, 1'b0, 1'b1);
    idle(70);
    check("t2_a_words", 32'(rx_a.size()), 32'd120);
    check("t2_a_first", word_at(0, 60), 32'h100);
    check("t2_a_last", word_at(0, 119), 32'h03B);

    // runt and oversize frames
    send_frame(10, 8'h20, 1'b0, 1'b1);
    send_frame(1519, 8'h00, 1'b0, 1'b1);
    idle(5);
    check("t3_a_drops", 32'(n_drop_a), 32'd3);
    check("t3_a_count", 32'(count_a), STAT ? 32'd3 : 32'd0);
    check("t3_a_words", 32'(rx_a.size()), 32'd120);
    check("t3_a_enable", 32'(bus_a.receive_data_enable), 32'h0);

    // overflow on the 16-word buffer, then a 14-byte frame fits
    ready = 1'b0;
    send_frame(20, 8'hC0, 1'b0, 1'b1);
    idle(3);
    send_frame(14, 8'hA0, 1'b0, 1'b1);
    idle(3);
    ready = 1'b1;
    idle(45);
    check("t4_b_drops", 32'(n_drop_b), 32'd6);
    check("t4_b_count", 32'(count_b), STAT ? 32'd6 : 32'd0);
    check("t4_b_words", 32'(rx_b.size()), 32'd14);
    check("t4_b_first", word_at(1, 0), 32'h1A0);
    check("t4_b_last", word_at(1, 13), 32'h0AD);
    check("t4_a_words", 32'(rx_a.size()), 32'd154);
    check("t4_a_first20", word_at(0, 120), 32'h1C0);

    // open frame aborted by a new start at byte 30
    send_frame(30, 8'h10, 1'b0, 1'b0);
    send_frame(64, 8'h40, 1'b0, 1'b1);
    idle(75);
    check("t5_a_drops", 32'(n_drop_a), 32'd4);
    check("t5_a_words", 32'(rx_a.size()), 32'd218);
    check("t5_a_first", word_at(0, 154), 32'h140);
    check("t5_a_last", word_at(0, 217), 32'h07F);

    // asynchronous reset while reading
    ready = 1'b0;
    send_frame(14, 8'h55, 1'b0, 1'b1);
    idle(3);
    check("t6_a_enable_pre", 32'(bus_a.receive_data_enable), 32'h1);
    ready = 1'b1;
    idle(4);
    #1 reset_n = 1'b0;
    #1;
    check("t6_a_enable", 32'(bus_a.receive_data_enable), 32'h0);
    check("t6_b_enable", 32'(bus_b.receive_data_enable), 32'h0);
    check("t6_a_committed", 32'(committed_a), 32'h0);
    check("t6_a_dropped", 32'(dropped_a), 32'h0);
    check("t6_a_count", 32'(count_a), 32'h0);
    check("t6_b_count", 32'(count_b), 32'h0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    idle(5);
    check("t6_a_empty", 32'(bus_a.receive_data_enable), 32'h0);
    check("t6_b_empty", 32'(bus_b.receive_data_enable), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/port_receive_frame_buffer.md
Name: port_receive_frame_buffer

Overview:
- Per-port store-and-forward receive buffer between an RMII receiver and core_data_orchestrator; one instance per RMII port.
- Accepts bytes with frame start/end/error flags and keeps only complete, good frames.
- Presents committed frames as 9-bit words (bit 8 = first byte of frame) on a valid/ready handshake matching the orchestrator's receive inputs.

Parameters:
- DEPTH_LOG2, 11, log2 of buffer depth in words (2048).
- MINIMUM_FRAME_LENGTH, 14, shortest frame in bytes that is committed.
- MAXIMUM_FRAME_LENGTH, 1518, longest frame in bytes that is committed.

Ports:
- clock  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte.
- rx_data_valid  input  1  rx_data valid this cycle.
- rx_frame_start  input  1  qualifies the first byte of a frame.
- rx_frame_end  input  1  qualifies the last byte of a frame.
- rx_frame_error  input  1  frame bad (FCS/PHY error); sampled with rx_frame_end.
- receive_data_ready  input  1  consumer accepts the word.
- receive_data  output  9  {first_flag, byte}; valid while receive_data_enable is 1.
- receive_data_enable  output  1  a committed word is available.
- frame_committed  output  1  one-cycle pulse when a frame is committed.
- frame_dropped  output  1  one-cycle pulse when a frame is discarded.
- dropped_frame_count  output  16  saturating count of discarded frames.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on reset_n.
- On reset, all pointers are cleared, the write FSM goes to W_IDLE, and the gap flag is cleared. All outputs reset to 0. Memory contents are not reset.
- Storage word is 10 bits: bit9 = last, bit8 = first, bits 7:0 = data.
- Pointers are DEPTH_LOG2+1 bits wide; the MSB distinguishes full from empty. All pointer arithmetic wraps modulo 2^(DEPTH_LOG2+1).
- Pointers:
  - spec_wp: speculative write pointer.
  - commit_wp: committed write pointer.
  - rp: read pointer.
- full = (spec_wp - rp) == 2^DEPTH_LOG2.
- Write FSM:
  - W_IDLE: on rx_data_valid & rx_frame_start, write the word with first=1 at spec_wp, set len=1, and go to W_RECEIVE. Bytes without a start flag are ignored.
  - W_RECEIVE: each valid byte is written at spec_wp, spec_wp increments, and len increments. len is an 11-bit counter that saturates.
    - A valid byte with rx_frame_start aborts the current frame: rollback, frame_dropped pulse, then restart with this byte.
    - A byte when full, or when len would exceed MAXIMUM_FRAME_LENGTH: rollback, frame_dropped pulse, go to W_DROP.
    - Valid & rx_frame_end: the byte is written with last=1. Then:
      - If rx_frame_error=1 or final len < MINIMUM_FRAME_LENGTH: rollback and frame_dropped pulse.
      - Otherwise: commit_wp = spec_wp+1 and frame_committed pulse.
      - In both cases, go to W_IDLE.
  - W_DROP: discard bytes until valid & rx_frame_end, then go to W_IDLE. A start flag seen here begins a new frame exactly as in W_IDLE.
  - Rollback means spec_wp <= commit_wp.
- Read side is show-ahead:
  - receive_data = mem[rp][8:0], read combinationally.
  - receive_data_enable = (rp != commit_wp) & !gap.
  - Pop on the clock edge where enable & ready: rp increments.
  - If the popped word has last=1, gap is set for exactly one cycle. This forces enable low between frames, which the orchestrator uses as its end-of-frame indication.
- Latency: the first byte of a frame is visible the cycle after its rx_frame_end byte is accepted, provided the buffer was empty and gap=0.
- Simultaneous pop and commit in the same cycle are both honoured. Full is evaluated against the pre-pop rp, so this check is conservative.
- A byte that arrives when full is never written, and the frame is dropped.
- dropped_frame_count increments on each frame_dropped pulse and saturates at 16'hFFFF.
- Reset mid-frame: the partial frame is lost; no frame_dropped pulse is generated.

Optional Feature:
- Macro: PORT_RECEIVE_FRAME_BUFFER_STATISTICS_EN.
- Defined: dropped_frame_count is implemented as specified.
- Undefined: the counter register is removed and dropped_frame_count is tied to 16'h0000. The frame_dropped and frame_committed pulses remain.

Decomposition:
- Package receive_frame_buffer_pkg contains:
  - Write-state enum: W_IDLE, W_RECEIVE, W_DROP.
  - Word bit indices: LAST_BIT=9, FIRST_BIT=8.
  - Defaults: 14, 1518, and 11.
- Sub-module frame_buffer_memory: simple dual-port RAM, 2^DEPTH_LOG2 x 10 bits, synchronous write and asynchronous read, no reset.

Test Plan:
- 60-byte good frame (bytes 0x00..0x3B), ready held 1 → 60 consecutive words; first is 0x100, the rest have bit8=0; enable is low for one cycle after 0x03B; frame_committed pulses once.
- Same frame with rx_frame_error=1 on the last byte → enable never rises; frame_dropped pulses once; dropped_frame_count=1; a following good frame is delivered intact.
- 10-byte frame, then 1519-byte frame → both are dropped; count=2; pointers are unchanged.
- DEPTH_LOG2=4, ready=0, 20-byte frame → overflow drop; a 14-byte frame written next is committed and then read out exactly.
- Start flag at byte 30 of an open frame, followed by a good 64-byte frame → only the 64-byte frame is delivered; one drop is counted.
- Assert reset_n=0 asynchronously mid-read → enable, frame_committed, frame_dropped, and count go to 0 immediately; the buffer is empty after release.
